tmds_channel_decoder: RTL and testbench
=======================================

// Module: tmds_channel_decoder
// PURPOSE
//  Receive-side counterpart of the TMDS channel encoder/serializer. Takes 10-bit parallel
//  characters from an external 1:10 deserializer (IDES10-class). Recovers word alignment by
//  requesting bit slips until control tokens appear. Decodes each aligned character to 8-bit
//  pixel data or 2-bit control, and flags alignment loss. One instance per TMDS channel.
// PARAMETERS
//  LOCK_TOKENS   8     consecutive control tokens needed to declare lock
//  SEARCH_WINDOW 1024  cycles in SEARCH without reaching lock before a bit slip is requested
//  SLIP_WAIT     4     cycles to ignore input after a bitSlip pulse (deserializer settle)
//  ERR_LIMIT     4     alignment errors while LOCKED that force return to SEARCH
// PORTS
//  pixelClock      in   1   single clock; the character rate
//  reset           in   1   synchronous, active-high
//  tmdsCharacterIn in   10  deserialized character; bit0 is first bit on the wire
//  bitSlip         out  1   one-cycle pulse; deserializer shifts its word boundary by one bit
//  locked          out  1   alignment achieved
//  pixelComponent  out  8   decoded D[7:0]; 0 when DE=0
//  controlBus      out  2   decoded {C1,C0}; updated only on control tokens, held otherwise
//  DE              out  1   1 = pixelComponent valid (data character while locked)
//  decodeError     out  1   one-cycle pulse per alignment error detected while LOCKED
// BEHAVIOUR
//  Reset: all outputs 0, state SEARCH, all counters 0. Applies mid-operation the same way.
//  Pipeline: stage 1 registers the input and classifies it (isControl, token value).
//   Stage 2 decodes. Input at cycle n appears on all outputs at cycle n+2.
//   locked and DE are aligned with the same character.
//  Control tokens: 1101010100=00, 0010101011=01, 0101010100=10, 1010101011=11 ({C1,C0}).
//  Data decode: d = w[9] ? ~w[7:0] : w[7:0]; out[0]=d[0].
//   For k=1..7: out[k] = w[8] ? d[k]^d[k-1] : ~(d[k]^d[k-1]).
//  DE = locked_stage2 & ~isControl. When not locked, DE=0 and pixelComponent=0.
//   controlBus still tracks control tokens when not locked.
//  ctlRun: count of consecutive control tokens, saturating at LOCK_TOKENS.
//   Cleared by any data character.
//  FSM:
//   SEARCH: timer increments each cycle.
//    ctlRun reaches LOCK_TOKENS -> LOCKED (timer and errCount cleared).
//    Else timer == SEARCH_WINDOW-1 -> SLIP.
//   SLIP: bitSlip=1 for exactly this one cycle -> WAIT.
//   WAIT: SLIP_WAIT cycles; ctlRun held at 0 -> SEARCH with timer=0.
//   LOCKED: locked=1.
//    Alignment error = a data character following a control run of length 1..LOCK_TOKENS-1.
//     Each error pulses decodeError and increments errCount (saturating).
//    A control run reaching LOCK_TOKENS clears errCount.
//    errCount == ERR_LIMIT -> SEARCH; locked drops in the same cycle the transition registers.
//    No control token for SEARCH_WINDOW cycles -> SEARCH (lost blanking).
//  Slips are unbounded: 10 slips return to the original phase, and the search continues.
//  Simultaneous events in LOCKED: errCount reaching ERR_LIMIT has priority over a
//   control-run clear on the same cycle.
//  In SLIP and WAIT, locked=0 and no errors are reported.
//  All counters saturate or are explicitly cleared; none wrap silently.
// TESTING
//  1 Reset, then 20x 1101010100: locked=1 at output of the 8th token; controlBus=00; DE=0; no bitSlip.
//  2 Locked, then 0100000000 then 1000000000: DE=1, pixelComponent 0x00 then 0xFF (2-cycle latency).
//  3 Bench deserializer rotated 3 bits, idle control stream: exactly 3 bitSlip pulses,
//    spaced SEARCH_WINDOW+SLIP_WAIT+1 cycles apart; then locked=1.
//  4 Locked; inject 4 isolated single control tokens between data: 4 decodeError pulses;
//    locked=0 after the 4th; FSM re-enters SEARCH.
//  5 Locked; data only for 1024 cycles: locked falls; search restarts.
//  6 Reset asserted mid-SLIP/WAIT: next cycle all outputs 0 and bitSlip=0; relock per scenario 1.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// ============================================================================
// Module      : tmds_channel_decoder
// Description : TMDS receive channel: word alignment via bit slips, character
//               decode to pixel/control data, alignment-loss detection.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_channel_decoder #(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_WINDOW = 1024,
  parameter int SLIP_WAIT     = 4,
  parameter int ERR_LIMIT     = 4
) (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic [9:0] tmdsCharacterIn,
  output logic       bitSlip,
  output logic       locked,
  output logic [7:0] pixelComponent,
  output logic [1:0] controlBus,
  output logic       DE,
  output logic       decodeError
);

  localparam int TW = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [TW-1:0] C_TIMER_LAST = TW'(SEARCH_WINDOW - 1);
  localparam logic [RW-1:0] C_RUN_FULL   = RW'(LOCK_TOKENS);
  localparam logic [EW-1:0] C_ERR_MAX    = EW'(ERR_LIMIT);
  localparam logic [WW-1:0] C_WAIT_LAST  = WW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SLIP   = 2'd1,
    S_WAIT   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t          r_state;
  logic [9:0]      r_s1_char;
  logic            r_s1_ctl;
  logic [1:0]      r_s1_tok;
  logic [TW-1:0]   r_timer;
  logic [RW-1:0]   r_run;
  logic [EW-1:0]   r_err_cnt;
  logic [WW-1:0]   r_wait_cnt;

  logic            w_in_ctl;
  logic [1:0]      w_in_tok;
  logic [7:0]      w_d;
  logic [7:0]      w_pix;
  logic [RW-1:0]   w_run_inc;
  logic [RW-1:0]   w_run_nxt;
  logic            w_run_full;
  logic            w_align_err;

  always_comb begin
    w_in_ctl = 1'b1;
    w_in_tok = 2'b00;
    case (tmdsCharacterIn)
      10'b1101010100: w_in_tok = 2'b00;
      10'b0010101011: w_in_tok = 2'b01;
      10'b0101010100: w_in_tok = 2'b10;
      10'b1010101011: w_in_tok = 2'b11;
      default:        w_in_ctl = 1'b0;
    endcase
  end

  // Undo the transition-minimising XOR/XNOR chain and optional inversion.
  always_comb begin
    w_d      = r_s1_char[9] ? ~r_s1_char[7:0] : r_s1_char[7:0];
    w_pix    = 8'h00;
    w_pix[0] = w_d[0];
    for (int k = 1; k < 8; k++) begin
      w_pix[k] = r_s1_char[8] ? (w_d[k] ^ w_d[k-1]) : ~(w_d[k] ^ w_d[k-1]);
    end
  end

  always_comb begin
    w_run_inc   = (r_run == C_RUN_FULL) ? r_run : r_run + 1'b1;
    w_run_nxt   = '0;
    if (r_state != S_SLIP && r_state != S_WAIT && r_s1_ctl) begin
      w_run_nxt = w_run_inc;
    end
    w_run_full  = r_s1_ctl && (w_run_inc == C_RUN_FULL);
    w_align_err = !r_s1_ctl && (r_run != '0) && (r_run < C_RUN_FULL);
  end

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      r_state        <= S_SEARCH;
      r_s1_char      <= '0;
      r_s1_ctl       <= 1'b0;
      r_s1_tok       <= '0;
      r_timer        <= '0;
      r_run          <= '0;
      r_err_cnt      <= '0;
      r_wait_cnt     <= '0;
      bitSlip        <= 1'b0;
      locked         <= 1'b0;
      pixelComponent <= '0;
      controlBus     <= '0;
      DE             <= 1'b0;
      decodeError    <= 1'b0;
    end else begin
      r_s1_char      <= tmdsCharacterIn;
      r_s1_ctl       <= w_in_ctl;
      r_s1_tok       <= w_in_tok;
      r_run          <= w_run_nxt;
      bitSlip        <= 1'b0;
      locked         <= 1'b0;
      pixelComponent <= '0;
      DE             <= 1'b0;
      decodeError    <= 1'b0;
      if (r_s1_ctl) begin
        controlBus <= r_s1_tok;
      end

      case (r_state)
        S_SEARCH: begin
          if (w_run_full) begin
            r_state   <= S_LOCKED;
            r_timer   <= '0;
            r_err_cnt <= '0;
            locked    <= 1'b1;
          end else if (r_timer == C_TIMER_LAST) begin
            r_state <= S_SLIP;
            r_timer <= '0;
            bitSlip <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_SLIP: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (r_wait_cnt == C_WAIT_LAST) begin
            r_state <= S_SEARCH;
            r_timer <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_LOCKED: begin
          // A saturated error count wins over anything this character does.
          if (r_err_cnt == C_ERR_MAX) begin
            r_state <= S_SEARCH;
            r_timer <= '0;
          end else begin
            locked         <= 1'b1;
            DE             <= !r_s1_ctl;
            pixelComponent <= r_s1_ctl ? 8'h00 : w_pix;
            if (w_align_err) begin
              decodeError <= 1'b1;
              r_err_cnt   <= (r_err_cnt == C_ERR_MAX) ? r_err_cnt : r_err_cnt + 1'b1;
            end else if (w_run_full) begin
              r_err_cnt <= '0;
            end
            if (r_s1_ctl) begin
              r_timer <= '0;
            end else if (r_timer == C_TIMER_LAST) begin
              r_state        <= S_SEARCH;
              r_timer        <= '0;
              locked         <= 1'b0;
              DE             <= 1'b0;
              pixelComponent <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        default: r_state <= S_SEARCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
// ============================================================================
// Module      : tb_tmds_channel_decoder
// Description : Randomised scoreboard bench with a bit-stream deserializer model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tmds_channel_decoder;

  localparam int LT  = 8;
  localparam int SW  = 1024;
  localparam int SWT = 4;
  localparam int EL  = 4;
  localparam int M_SEARCH = 0, M_SLIP = 1, M_WAIT = 2, M_LOCKED = 3;
  localparam logic [9:0] TOKENS [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] char_in = '0;
  logic       bit_slip, locked, de, derr;
  logic [7:0] pix;
  logic [1:0] cbus;

  tmds_channel_decoder #(
    .LOCK_TOKENS(LT), .SEARCH_WINDOW(SW), .SLIP_WAIT(SWT), .ERR_LIMIT(EL)
  ) dut (
    .pixelClock(clk), .reset(rst), .tmdsCharacterIn(char_in),
    .bitSlip(bit_slip), .locked(locked), .pixelComponent(pix),
    .controlBus(cbus), .DE(de), .decodeError(derr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int exp_t[$];
  logic [13:0] exp_v[$];
  int slip_q[$];
  int derr_cnt = 0;

  // Reference model state
  int m_mode, m_timer, m_wait, m_run, m_errs;
  logic [1:0] m_cb;
  // Bench deserializer: current misalignment in bits and previous character
  int mis = 0;
  logic [9:0] prev_c = '0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bit_slip === 1'b1) slip_q.push_back(cyc);
    if (derr === 1'b1) derr_cnt++;
    if (exp_t.size() > 0 && exp_t[0] == cyc) begin
      logic [13:0] act;
      logic [13:0] e;
      act = {bit_slip, locked, pix, cbus, de, derr};
      e = exp_v.pop_front();
      void'(exp_t.pop_front());
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL outputs@%0d {slip,lock,pix,cbus,de,err}: got %h expected %h", cyc, act, e);
      end
    end
  end

  function automatic bit is_tok(input logic [9:0] w, output logic [1:0] tok);
    is_tok = 1'b0;
    tok = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (w == TOKENS[i]) begin
        is_tok = 1'b1;
        tok = 2'(i);
      end
    end
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] o;
    d = w[9] ? ~w[7:0] : w[7:0];
    o[0] = d[0];
    for (int k = 1; k < 8; k++) o[k] = d[k] ^ d[k-1] ^ ~w[8];
    return o;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] v;
    logic [1:0] t;
    v = 10'($urandom_range(0, 1023));
    while (is_tok(v, t)) v = 10'($urandom_range(0, 1023));
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_SEARCH; m_timer = 0; m_wait = 0; m_run = 0; m_errs = 0; m_cb = 2'b00;
  endtask

  task automatic model_step(input logic [9:0] w, output logic [13:0] e);
    bit ctl, err, lk;
    logic [1:0] tok;
    int prior;
    ctl = is_tok(w, tok);
    if (ctl) m_cb = tok;
    prior = m_run;
    if (m_mode == M_SLIP || m_mode == M_WAIT) m_run = 0;
    else m_run = ctl ? ((m_run >= LT) ? LT : m_run + 1) : 0;
    err = 1'b0;
    case (m_mode)
      M_SEARCH:
        if (m_run == LT) begin m_mode = M_LOCKED; m_timer = 0; m_errs = 0; end
        else if (m_timer == SW - 1) begin m_mode = M_SLIP; m_timer = 0; end
        else m_timer++;
      M_SLIP: begin m_mode = M_WAIT; m_wait = 0; end
      M_WAIT:
        if (m_wait == SWT - 1) begin m_mode = M_SEARCH; m_timer = 0; end
        else m_wait++;
      default:
        if (m_errs >= EL) begin m_mode = M_SEARCH; m_timer = 0; end
        else begin
          if (!ctl && prior > 0 && prior < LT) begin err = 1'b1; m_errs++; end
          else if (ctl && m_run == LT) m_errs = 0;
          if (ctl) m_timer = 0;
          else if (m_timer == SW - 1) begin m_mode = M_SEARCH; m_timer = 0; end
          else m_timer++;
        end
    endcase
    lk = (m_mode == M_LOCKED);
    e = {m_mode == M_SLIP, lk, (lk && !ctl) ? ref_decode(w) : 8'h00, m_cb, lk && !ctl, err};
  endtask

  // Drive one wire character through the bench deserializer for one cycle.
  task automatic send(input logic [9:0] c);
    logic [19:0] pair;
    logic [9:0] w;
    logic [13:0] e;
    if (bit_slip === 1'b1) mis = (mis + 9) % 10;
    pair = {c, prev_c};
    w = (mis == 0) ? c : 10'(pair >> (10 - mis));
    prev_c = c;
    char_in = w;
    model_step(w, e);
    exp_t.push_back(cyc + 2);
    exp_v.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    logic [13:0] e;
    rst = 1'b1;
    while (exp_t.size() > 0 && exp_t[$] > cyc) begin
      void'(exp_t.pop_back());
      void'(exp_v.pop_back());
    end
    for (int i = 1; i <= n; i++) begin
      exp_t.push_back(cyc + i);
      exp_v.push_back('0);
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_reset();
    model_step(10'h000, e);
    exp_t.push_back(cyc + 1);
    exp_v.push_back(e);
  endtask

  initial begin
    bit seen;
    model_reset();
    @(posedge clk); #1;
    do_reset(3);

    // Aligned idle stream locks on the eighth token
    slip_q.delete();
    for (int i = 0; i < 20; i++) send(TOKENS[0]);
    send(TOKENS[0]); send(TOKENS[0]);
    check("t1_locked", int'(locked), 1);
    check("t1_cbus", int'(cbus), 0);
    check("t1_de", int'(de), 0);
    check("t1_no_slip", slip_q.size(), 0);

    // Data decode extremes, two-cycle latency
    send(10'b0100000000);
    send(10'b1000000000);
    check("t2_pix00", int'(pix), 8'h00);
    check("t2_de0", int'(de), 1);
    send(TOKENS[2]);
    check("t2_pixff", int'(pix), 8'hFF);
    check("t2_de1", int'(de), 1);

    // Random segments of control runs and data
    for (int s = 0; s < 40; s++) begin
      int nc, nd;
      nc = $urandom_range(1, 12);
      nd = $urandom_range(1, 16);
      for (int i = 0; i < nc; i++) send(TOKENS[$urandom_range(0, 3)]);
      for (int i = 0; i < nd; i++) send(10'($urandom_range(0, 1023)));
    end

    // Rotated stream needs three slips
    do_reset(2);
    mis = 3;
    slip_q.delete();
    for (int i = 0; i < 3400; i++) send(TOKENS[0]);
    check("t3_slip_count", slip_q.size(), 3);
    if (slip_q.size() >= 3) begin
      check("t3_spacing1", slip_q[1] - slip_q[0], SW + SWT + 1);
      check("t3_spacing2", slip_q[2] - slip_q[1], SW + SWT + 1);
    end
    check("t3_locked", int'(locked), 1);

    // Isolated single tokens between data characters
    derr_cnt = 0;
    send(rand_data());
    for (int i = 0; i < 4; i++) begin
      send(TOKENS[$urandom_range(0, 3)]);
      send(rand_data());
    end
    for (int i = 0; i < 4; i++) send(rand_data());
    check("t4_errors", derr_cnt, 4);
    check("t4_unlocked", int'(locked), 0);

    // Lost blanking
    for (int i = 0; i < 12; i++) send(TOKENS[1]);
    check("t5_relocked", int'(locked), 1);
    for (int i = 0; i < SW + 3; i++) send(rand_data());
    check("t5_lost", int'(locked), 0);

    // Reset in the middle of a slip sequence
    mis = 5;
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      send(TOKENS[0]);
      if (bit_slip === 1'b1) seen = 1'b1;
    end
    check("t6_slip_seen", int'(seen), 1);
    send(TOKENS[0]); send(TOKENS[0]);
    do_reset(1);
    check("t6_reset_outputs", int'({bit_slip, locked, pix, cbus, de, derr}), 0);
    mis = 0;
    for (int i = 0; i < 22; i++) send(TOKENS[3]);
    check("t6_relocked", int'(locked), 1);
    check("t6_cbus", int'(cbus), 3);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_t.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
